// File: rtl/hog_pkg.sv
// hog_pkg: shared FSM type, bank count and beat geometry
// helper for the HOG row unpacker.
package hog_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_e;

  localparam int HOG_NBANK = 4;

  function automatic int ppb(
    input int axi_dw,
    input int p_width
  );
    return axi_dw / p_width;
  endfunction

endpackage

// File: rtl/hog_row_unpacker_if.sv
// hog_row_unpacker_if: valid/ready beat stream feeding
// the row unpacker.
interface hog_row_unpacker_if #(
  parameter int AXI_DW = 512
);

  logic              s_valid;
  logic              s_ready;
  logic [AXI_DW-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/hog_beat_shifter.sv
// hog_beat_shifter: holds one beat and presents one pixel
// per cycle, counting down the pixels still to emit.
module hog_beat_shifter
  import hog_pkg::*;
#(
  parameter int AXI_DW  = 512,
  parameter int P_WIDTH = 8,
  localparam int CW     = $clog2(ppb(AXI_DW, P_WIDTH) + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [AXI_DW-1:0]  load_data,
  input  logic [CW-1:0]      load_n,
  output logic [P_WIDTH-1:0] pix,
  output logic [CW-1:0]      cnt
);

  logic [AXI_DW-1:0] beat_q, beat_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (load) begin
      beat_d = load_data;
      cnt_d  = load_n;
    end else if (cnt_q != '0) begin
      beat_d = beat_q >> P_WIDTH;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      cnt_q  <= '0;
    end else begin
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pix = beat_q[P_WIDTH-1:0];
  assign cnt = cnt_q;

endmodule

// File: rtl/hog_row_unpacker.sv
// hog_row_unpacker: serialises stream beats into pixels and
// writes each image row into one of four interleaved banks.
module hog_row_unpacker
  import hog_pkg::*;
#(
  parameter int AXI_DW  = 512,
  parameter int P_WIDTH = 8,
  parameter int RAM_AW  = 17
) (
  input  logic                 aclk,
  input  logic                 arest,
  input  logic                 start,
  input  logic [15:0]          img_w,
  input  logic [15:0]          img_h,
  hog_row_unpacker_if.slave    s,
  output logic [HOG_NBANK-1:0] bank_we,
  output logic [RAM_AW-1:0]    bank_addr,
  output logic [P_WIDTH-1:0]   bank_din,
  output logic [15:0]          row_cnt,
  output logic                 row_done,
  output logic                 busy,
  output logic                 done
);

  localparam int PPB = ppb(AXI_DW, P_WIDTH);
  localparam int CW  = $clog2(PPB + 1);
  localparam logic [15:0] PPB16 = 16'(PPB);

  state_e state_q, state_d;
  logic [15:0] w_q, w_d;
  logic [15:0] h_q, h_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [1:0]  bank_q, bank_d;
  logic [31:0] base_q, base_d;
  logic        eol_q, eol_d;
  logic [HOG_NBANK-1:0] we_q, we_d;
  logic [RAM_AW-1:0]    addr_q, addr_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        rdone_q, rdone_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;

  logic [15:0]        rem;
  logic [15:0]        n16;
  logic [15:0]        col_nx;
  logic               eol_nx;
  logic               ld;
  logic [CW-1:0]      sh_cnt;
  logic [P_WIDTH-1:0] sh_pix;

  assign rem    = w_q - col_q;
  assign n16    = (rem > PPB16) ? PPB16 : rem;
  assign col_nx = col_q + n16;
  assign eol_nx = (col_nx == w_q);
  assign ld     = (state_q == LOAD) && s.s_valid;

  hog_beat_shifter #(
    .AXI_DW (AXI_DW),
    .P_WIDTH(P_WIDTH)
  ) u_shift (
    .clk      (aclk),
    .rst      (arest),
    .load     (ld),
    .load_data(s.s_data),
    .load_n   (CW'(n16)),
    .pix      (sh_pix),
    .cnt      (sh_cnt)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    row_d   = row_q;
    col_d   = col_q;
    bank_d  = bank_q;
    base_d  = base_q;
    eol_d   = eol_q;
    we_d    = we_q;
    addr_d  = addr_q;
    rcnt_d  = rcnt_q;
    rdone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d    = img_w;
          h_d    = img_h;
          row_d  = '0;
          col_d  = '0;
          bank_d = '0;
          base_d = '0;
          rcnt_d = '0;
          if (img_w == '0 || img_h == '0)
            state_d = DONE;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (s.s_valid) begin
          eol_d   = eol_nx;
          col_d   = eol_nx ? 16'd0 : col_nx;
          we_d    = HOG_NBANK'(1) << bank_q;
          addr_d  = RAM_AW'(base_q + {16'd0, col_q});
          rdone_d = eol_nx && (n16 == 16'd1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sh_cnt == CW'(1)) begin
          we_d    = '0;
          state_d = LOAD;
          if (eol_q) begin
            row_d  = row_q + 16'd1;
            bank_d = bank_q + 2'd1;
            // bank 3 closes a group of four rows
            if (bank_q == 2'd3)
              base_d = base_q + {16'd0, w_q};
            if (row_q + 16'd1 == h_q)
              state_d = DONE;
          end
        end else begin
          addr_d  = addr_q + RAM_AW'(1);
          rdone_d = eol_q && (sh_cnt == CW'(2));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
    if (rdone_d)
      rcnt_d = rcnt_q + 16'd1;
    busy_d = (state_d == LOAD) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    rdy_d  = (state_d == LOAD);
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      bank_q  <= '0;
      base_q  <= '0;
      eol_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      rcnt_q  <= '0;
      rdone_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bank_q  <= bank_d;
      base_q  <= base_d;
      eol_q   <= eol_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      rcnt_q  <= rcnt_d;
      rdone_q <= rdone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign s.s_ready = rdy_q;
  assign bank_we   = we_q;
  assign bank_addr = addr_q;
  assign bank_din  = sh_pix;
  assign row_cnt   = rcnt_q;
  assign row_done  = rdone_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hog_row_unpacker.sv
// tb_hog_row_unpacker: table-driven image transfers plus
// reset and restart corner sequences for hog_row_unpacker.
module tb_hog_row_unpacker;

  logic        aclk = 1'b0;
  logic        arest;
  logic        start;
  logic [15:0] img_w, img_h;
  logic [3:0]  bank_we;
  logic [16:0] bank_addr;
  logic [7:0]  bank_din;
  logic [15:0] row_cnt;
  logic        row_done, busy, done;

  hog_row_unpacker_if #(.AXI_DW(512)) sv ();

  hog_row_unpacker #(
    .AXI_DW (512),
    .P_WIDTH(8),
    .RAM_AW (17)
  ) dut (
    .aclk     (aclk),
    .arest    (arest),
    .start    (start),
    .img_w    (img_w),
    .img_h    (img_h),
    .s        (sv),
    .bank_we  (bank_we),
    .bank_addr(bank_addr),
    .bank_din (bank_din),
    .row_cnt  (row_cnt),
    .row_done (row_done),
    .busy     (busy),
    .done     (done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int w; int h; int pct; int cyc; int wr;
    int rows; int gap; int maxa; int restart; bit sod;
  } vec_t;

  vec_t vt [8];
  int nvec = 0;
  int nmis = 0;

  // monitor state
  logic [7:0] bmem [4][131072];
  bit  mon_en = 0;
  int  mon_err, rd_cnt, ncyc, last_rd, cur_w, gap_exp;
  int  wr_cnt [4];
  int  max_addr;
  bit  lastcol;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (mon_en) begin
      lastcol = 0;
      if (bank_we != 4'd0) begin
        int kk, r, c;
        kk = 0;
        if (!$onehot(bank_we)) mon_err++;
        for (int k = 0; k < 4; k++) if (bank_we[k]) kk = k;
        if (cur_w == 0) mon_err++;
        else begin
          r = (int'(bank_addr) / cur_w) * 4 + kk;
          c = int'(bank_addr) % cur_w;
          if (bank_din !== 8'((r + c) & 255)) mon_err++;
          lastcol = (c == cur_w - 1);
        end
        bmem[kk][bank_addr] = bank_din;
        wr_cnt[kk]++;
        if (int'(bank_addr) > max_addr) max_addr = int'(bank_addr);
        if (sv.s_ready) mon_err++;
      end
      if (row_done) begin
        if (!lastcol) mon_err++;
        if (int'(row_cnt) != rd_cnt + 1) mon_err++;
        if (gap_exp > 0 && rd_cnt > 0 && ncyc - last_rd != gap_exp)
          mon_err++;
        last_rd = ncyc;
        rd_cnt++;
      end
      ncyc++;
    end
  end

  function automatic logic [511:0] make_beat(int r, int c, int w);
    logic [511:0] b;
    for (int i = 0; i < 64; i++)
      b[8*i +: 8] = (c + i < w) ? 8'((r + c + i) & 255) : 8'hEE;
    return b;
  endfunction

  task automatic run_and_check(input vec_t v, input string tag);
    int d, limit, drow, dcol;
    bit seen, busy_seen, hs, busy_at_done;
    mon_err = 0; rd_cnt = 0; ncyc = 0; last_rd = 0;
    max_addr = 0; cur_w = v.w; gap_exp = v.gap;
    for (int k = 0; k < 4; k++) wr_cnt[k] = 0;
    drow = 0; dcol = 0;
    @(negedge aclk);
    img_w = 16'(v.w); img_h = 16'(v.h); start = 1'b1;
    sv.s_valid = ($urandom_range(0, 99) < v.pct);
    sv.s_data  = make_beat(drow, dcol, v.w);
    mon_en = 1;
    d = 0; seen = 0; busy_seen = 0; busy_at_done = 0;
    limit = (v.cyc > 0) ? v.cyc + 50 : 40000;
    while (!seen && d < limit) begin
      hs = sv.s_valid && sv.s_ready;
      @(negedge aclk);
      d++;
      start = 1'b0;
      if (v.restart != 0 && d == v.restart) begin
        start = 1'b1; img_w = 16'd5; img_h = 16'd3;
      end
      if (hs) begin
        dcol += 64;
        if (dcol >= v.w) begin dcol = 0; drow++; end
      end
      sv.s_valid = ($urandom_range(0, 99) < v.pct);
      sv.s_data  = make_beat(drow, dcol, v.w);
      if (busy) busy_seen = 1;
      if (done) begin seen = 1; busy_at_done = busy; end
    end
    mon_en = 0;
    chk({tag, " done_seen"}, seen, 1);
    if (v.cyc >= 0) chk({tag, " done_cycle"}, d, v.cyc);
    chk({tag, " writes"},
        wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3], v.wr);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s bank%0d_writes", tag, k), wr_cnt[k],
          (v.h > k) ? ((v.h - 1 - k) / 4 + 1) * v.w : 0);
    chk({tag, " max_addr"}, max_addr, v.maxa);
    chk({tag, " row_cnt"}, row_cnt, v.rows);
    chk({tag, " row_dones"}, rd_cnt, v.rows);
    chk({tag, " monitor_errs"}, mon_err, 0);
    chk({tag, " busy_seen"}, busy_seen, (v.wr > 0));
    chk({tag, " busy_at_done"}, busy_at_done, 0);
    if (v.sod && seen) begin
      start = 1'b1; img_w = 16'd64; img_h = 16'd4;
      @(negedge aclk);
      start = 1'b0;
      chk({tag, " start_on_done_ignored"}, {busy, sv.s_ready}, 0);
    end
  endtask

  initial begin
    vt[0] = '{136, 136, 100, 18905, 18496, 136, 139, 4623, 0, 0};
    vt[1] = '{64, 4, 100, 261, 256, 4, 65, 63, 0, 0};
    vt[2] = '{136, 8, 30, -1, 1088, 8, 0, 271, 0, 0};
    vt[3] = '{0, 5, 100, 1, 0, 0, 0, 0, 0, 0};
    vt[4] = '{5, 3, 100, 19, 15, 3, 6, 4, 0, 1};
    vt[5] = '{130, 5, 100, 666, 650, 5, 133, 259, 0, 0};
    vt[6] = '{7, 0, 100, 1, 0, 0, 0, 0, 0, 1};
    vt[7] = '{64, 4, 100, 261, 256, 4, 65, 63, 100, 0};

    arest = 1'b1; start = 1'b0; img_w = '0; img_h = '0;
    sv.s_valid = 1'b0; sv.s_data = '0;
    repeat (3) @(negedge aclk);
    chk("reset_state",
        {sv.s_ready, bank_we, bank_addr, bank_din,
         row_cnt, row_done, busy, done}, 0);
    arest = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_and_check(vt[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("b1_a0", bmem[1][0], 1);
        chk("b0_a135", bmem[0][135], 135);
        chk("b0_a136", bmem[0][136], 4);
        chk("b3_a135", bmem[3][135], 138);
      end
    end

    // reset in the middle of row 2, then a fresh transfer
    begin
      int n;
      bit hit;
      @(negedge aclk);
      img_w = 16'd136; img_h = 16'd136; start = 1'b1;
      sv.s_valid = 1'b1; sv.s_data = make_beat(0, 0, 136);
      @(negedge aclk);
      start = 1'b0;
      hit = 0;
      for (n = 0; n < 1000 && !hit; n++) begin
        @(negedge aclk);
        if (row_cnt == 16'd2) hit = 1;
      end
      chk("rst_mid reached_row2", hit, 1);
      repeat (50) @(negedge aclk);
      arest = 1'b1;
      @(negedge aclk);
      chk("rst_mid outputs_zero",
          {sv.s_ready, bank_we, bank_addr, bank_din,
           row_cnt, row_done, busy, done}, 0);
      arest = 1'b0;
      sv.s_valid = 1'b0;
      run_and_check(vt[1], "after_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
